// File: rtl/fetch_packet_splitter_pkg.sv
// Shared types for the fetch-to-instruction-fifo path: the {pc, inst} entry
// that the splitter produces and that the fifo and decode consume.
package fetch_packet_splitter_pkg;

    localparam int FP_ADDR_WIDTH     = 32;
    localparam int FP_INST_WIDTH     = 32;
    localparam int FP_FETCH_WIDTH    = 4;
    localparam int FP_INST_BYTES     = 4;
    localparam int FETCH_ENTRY_WIDTH = FP_ADDR_WIDTH + FP_INST_WIDTH;

    typedef struct packed {
        logic [FP_ADDR_WIDTH-1:0] pc;
        logic [FP_INST_WIDTH-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_packet_splitter_lsb_priority_encoder.sv
// Finds the lowest set bit of a mask, returning its index, a one-hot copy of
// that bit and whether any bit is set.
module lsb_priority_encoder #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0]         mask,
    output logic [$clog2(WIDTH)-1:0] index,
    output logic                     any,
    output logic [WIDTH-1:0]         onehot
);

    localparam int IDX_W = $clog2(WIDTH);

    // Scan from the top down so the lowest set bit wins last.
    always_comb begin
        index = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                index = IDX_W'(i);
            end
        end
    end

    assign onehot = mask & (~mask + WIDTH'(1));
    assign any    = |mask;

endmodule

// File: rtl/fetch_packet_splitter.sv
// Holds one fetch packet and emits its valid slots, lowest index first, one
// {pc, inst} entry per cycle into the instruction fifo push port.
module fetch_packet_splitter
    import fetch_packet_splitter_pkg::*;
#(
    parameter int FETCH_WIDTH = FP_FETCH_WIDTH,
    parameter int INST_WIDTH  = FP_INST_WIDTH,
    parameter int ADDR_WIDTH  = FP_ADDR_WIDTH,
    parameter int INST_BYTES  = FP_INST_BYTES
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              flush,
    input  logic                              pkt_valid,
    output logic                              pkt_ready,
    input  logic [ADDR_WIDTH-1:0]             pkt_pc,
    input  logic [FETCH_WIDTH*INST_WIDTH-1:0] pkt_inst,
    input  logic [FETCH_WIDTH-1:0]            pkt_mask,
    output logic [ADDR_WIDTH+INST_WIDTH-1:0]  fifo_data_in,
    output logic                              fifo_push,
    input  logic                              fifo_full,
    output logic                              busy
);

    localparam int IDX_W = $clog2(FETCH_WIDTH);

    logic                              hold_valid;
    logic [ADDR_WIDTH-1:0]             hold_pc;
    logic [FETCH_WIDTH*INST_WIDTH-1:0] hold_inst;
    logic [FETCH_WIDTH-1:0]            rem_mask;

    logic [IDX_W-1:0]       cur;
    logic                   rem_any;
    logic [FETCH_WIDTH-1:0] cur_onehot;
    logic                   last;
    logic                   accept;
    logic [ADDR_WIDTH-1:0]  cur_pc;
    logic [INST_WIDTH-1:0]  cur_inst;

    lsb_priority_encoder #(
        .WIDTH (FETCH_WIDTH)
    ) u_slot_sel (
        .mask   (rem_mask),
        .index  (cur),
        .any    (rem_any),
        .onehot (cur_onehot)
    );

    assign busy      = hold_valid && rem_any;
    assign fifo_push = busy && !fifo_full && !flush;
    assign last      = fifo_push && ((rem_mask & ~cur_onehot) == '0);
    assign pkt_ready = !flush && (!busy || last);
    assign accept    = pkt_valid && pkt_ready;

    // PC offset wraps naturally at ADDR_WIDTH bits.
    assign cur_pc       = hold_pc + (ADDR_WIDTH'(cur) * ADDR_WIDTH'(INST_BYTES));
    assign cur_inst     = hold_inst[cur*INST_WIDTH +: INST_WIDTH];
    assign fifo_data_in = {cur_pc, cur_inst};

    // A new accept replaces whatever the final push would have cleared.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            hold_valid <= 1'b0;
            rem_mask   <= '0;
        end else if (accept) begin
            hold_pc    <= pkt_pc;
            hold_inst  <= pkt_inst;
            rem_mask   <= pkt_mask;
            hold_valid <= (pkt_mask != '0);
        end else if (fifo_push) begin
            rem_mask <= rem_mask & ~cur_onehot;
            if (last) begin
                hold_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_packet_splitter.sv
// Directed bench for fetch_packet_splitter with hand-computed push sequences.
module tb_fetch_packet_splitter;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          pkt_valid;
    logic          pkt_ready;
    logic [31:0]   pkt_pc;
    logic [127:0]  pkt_inst;
    logic [3:0]    pkt_mask;
    logic [63:0]   fifo_data_in;
    logic          fifo_push;
    logic          fifo_full;
    logic          busy;

    int total;
    int bad;

    localparam logic [31:0] IA = 32'hAAAA_0001;
    localparam logic [31:0] IB = 32'hBBBB_0002;
    localparam logic [31:0] IC = 32'hCCCC_0003;
    localparam logic [31:0] ID = 32'hDDDD_0004;
    localparam logic [31:0] IE = 32'hEEEE_0005;
    localparam logic [31:0] IF = 32'hFFFF_0006;
    localparam logic [31:0] IG = 32'h1234_0007;
    localparam logic [31:0] IH = 32'h5678_0008;

    fetch_packet_splitter dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .pkt_valid    (pkt_valid),
        .pkt_ready    (pkt_ready),
        .pkt_pc       (pkt_pc),
        .pkt_inst     (pkt_inst),
        .pkt_mask     (pkt_mask),
        .fifo_data_in (fifo_data_in),
        .fifo_push    (fifo_push),
        .fifo_full    (fifo_full),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [127:0] inst,
                                 input logic [3:0] mask, input logic full, input logic fl);
        pkt_valid = v;
        pkt_pc    = pc;
        pkt_inst  = inst;
        pkt_mask  = mask;
        fifo_full = full;
        flush     = fl;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 32'h0, 128'h0, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic expectPush(input string tag, input logic [31:0] pc, input logic [31:0] inst);
        checkOutput({tag, "_push"}, 64'(fifo_push), 64'd1);
        checkOutput({tag, "_data"}, fifo_data_in, {pc, inst});
    endtask

    task automatic expectIdle(input string tag);
        checkOutput({tag, "_push"}, 64'(fifo_push), 64'd0);
        checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
        checkOutput({tag, "_ready"}, 64'(pkt_ready), 64'd1);
    endtask

    initial begin
        logic [127:0] pkt_abcd;
        logic [127:0] pkt_efgh;
        total    = 0;
        bad      = 0;
        pkt_abcd = {ID, IC, IB, IA};
        pkt_efgh = {IH, IG, IF, IE};

        rst = 1'b1;
        idle();
        next_cycle();
        next_cycle();
        sample();
        expectIdle("reset");
        rst = 1'b0;
        next_cycle();

        // Full packet then a back-to-back second packet.
        applyStimulus(1'b1, 32'h1000, pkt_abcd, 4'b1111, 1'b0, 1'b0);
        sample();
        checkOutput("t1_acc_ready", 64'(pkt_ready), 64'd1);
        checkOutput("t1_acc_push", 64'(fifo_push), 64'd0);
        next_cycle();
        idle();
        sample();
        expectPush("t1_s0", 32'h1000, IA);
        checkOutput("t1_s0_ready", 64'(pkt_ready), 64'd0);
        checkOutput("t1_s0_busy", 64'(busy), 64'd1);
        next_cycle();
        sample();
        expectPush("t1_s1", 32'h1004, IB);
        checkOutput("t1_s1_ready", 64'(pkt_ready), 64'd0);
        next_cycle();
        sample();
        expectPush("t1_s2", 32'h1008, IC);
        next_cycle();
        applyStimulus(1'b1, 32'h1010, pkt_efgh, 4'b1111, 1'b0, 1'b0);
        sample();
        expectPush("t1_s3", 32'h100C, ID);
        checkOutput("t1_s3_ready", 64'(pkt_ready), 64'd1);
        next_cycle();
        idle();
        sample();
        expectPush("t1_p2s0", 32'h1010, IE);
        next_cycle();
        sample();
        expectPush("t1_p2s1", 32'h1014, IF);
        next_cycle();
        sample();
        expectPush("t1_p2s2", 32'h1018, IG);
        next_cycle();
        sample();
        expectPush("t1_p2s3", 32'h101C, IH);
        next_cycle();
        sample();
        expectIdle("t1_done");

        // Sparse mask, then an all-zero mask.
        applyStimulus(1'b1, 32'h2000, pkt_abcd, 4'b1010, 1'b0, 1'b0);
        next_cycle();
        idle();
        sample();
        expectPush("t2_s1", 32'h2004, IB);
        checkOutput("t2_s1_ready", 64'(pkt_ready), 64'd0);
        next_cycle();
        sample();
        expectPush("t2_s3", 32'h200C, ID);
        checkOutput("t2_s3_ready", 64'(pkt_ready), 64'd1);
        next_cycle();
        sample();
        expectIdle("t2_done");
        applyStimulus(1'b1, 32'h2100, pkt_abcd, 4'b0000, 1'b0, 1'b0);
        sample();
        checkOutput("t2_zero_ready", 64'(pkt_ready), 64'd1);
        next_cycle();
        idle();
        sample();
        expectIdle("t2_zero_after");

        // Backpressure after the first push.
        applyStimulus(1'b1, 32'h3000, pkt_abcd, 4'b1111, 1'b0, 1'b0);
        next_cycle();
        idle();
        sample();
        expectPush("t3_s0", 32'h3000, IA);
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 32'h0, 128'h0, 4'h0, 1'b1, 1'b0);
            sample();
            checkOutput("t3_full_push", 64'(fifo_push), 64'd0);
            checkOutput("t3_full_data", fifo_data_in, {32'h3004, IB});
            checkOutput("t3_full_ready", 64'(pkt_ready), 64'd0);
            next_cycle();
        end
        idle();
        sample();
        expectPush("t3_s1", 32'h3004, IB);
        next_cycle();
        sample();
        expectPush("t3_s2", 32'h3008, IC);
        next_cycle();
        sample();
        expectPush("t3_s3", 32'h300C, ID);
        next_cycle();
        sample();
        expectIdle("t3_done");

        // Flush after two pushes.
        applyStimulus(1'b1, 32'h4000, pkt_abcd, 4'b1111, 1'b0, 1'b0);
        next_cycle();
        idle();
        sample();
        expectPush("t4_s0", 32'h4000, IA);
        next_cycle();
        sample();
        expectPush("t4_s1", 32'h4004, IB);
        next_cycle();
        applyStimulus(1'b0, 32'h0, 128'h0, 4'h0, 1'b0, 1'b1);
        sample();
        checkOutput("t4_flush_push", 64'(fifo_push), 64'd0);
        checkOutput("t4_flush_ready", 64'(pkt_ready), 64'd0);
        next_cycle();
        idle();
        sample();
        expectIdle("t4_after");

        // New packet starts at slot 0; flush lands on its last slot.
        applyStimulus(1'b1, 32'h5000, pkt_efgh, 4'b1111, 1'b0, 1'b0);
        next_cycle();
        idle();
        sample();
        expectPush("t5_s0", 32'h5000, IE);
        next_cycle();
        sample();
        expectPush("t5_s1", 32'h5004, IF);
        next_cycle();
        sample();
        expectPush("t5_s2", 32'h5008, IG);
        next_cycle();
        applyStimulus(1'b1, 32'h6000, pkt_abcd, 4'b1111, 1'b0, 1'b1);
        sample();
        checkOutput("t5_flush_push", 64'(fifo_push), 64'd0);
        checkOutput("t5_flush_ready", 64'(pkt_ready), 64'd0);
        next_cycle();
        idle();
        sample();
        expectIdle("t5_after");
        next_cycle();
        sample();
        checkOutput("t5_no_accept", 64'(fifo_push), 64'd0);

        // PC wrap across the top of the address space.
        applyStimulus(1'b1, 32'hFFFF_FFF8, pkt_abcd, 4'b1111, 1'b0, 1'b0);
        next_cycle();
        idle();
        sample();
        expectPush("t6_s0", 32'hFFFF_FFF8, IA);
        next_cycle();
        sample();
        expectPush("t6_s1", 32'hFFFF_FFFC, IB);
        next_cycle();
        sample();
        expectPush("t6_s2", 32'h0000_0000, IC);
        next_cycle();
        sample();
        expectPush("t6_s3", 32'h0000_0004, ID);
        next_cycle();
        sample();
        expectIdle("t6_done");

        // Reset mid-packet drops the remaining slots.
        applyStimulus(1'b1, 32'h7000, pkt_efgh, 4'b1111, 1'b0, 1'b0);
        next_cycle();
        idle();
        sample();
        expectPush("t7_s0", 32'h7000, IE);
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        sample();
        expectIdle("t7_rst");
        next_cycle();
        sample();
        expectIdle("t7_rst_after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_packet_splitter.md
Name: fetch_packet_splitter

Overview:
- Upstream neighbour of the instruction fifo: a FETCH_WIDTH-wide fetch packet (base PC, instruction slots, slot-valid mask) enters; one {pc, instruction} entry per cycle leaves into the fifo's single-entry push port.
- Absorbs fifo backpressure through `fifo_full` and throttles fetch through `pkt_ready`.
- Drops all held work on pipeline flush.

Parameters:
- FETCH_WIDTH, 4, instruction slots per fetch packet (power of two, ≥2).
- INST_WIDTH, 32, bits per instruction slot.
- ADDR_WIDTH, 32, PC width.
- INST_BYTES, 4, byte stride between consecutive slots.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  pipeline flush; discard held packet.
- pkt_valid  in  1  fetch offers a packet.
- pkt_ready  out  1  splitter accepts packet this cycle.
- pkt_pc  in  ADDR_WIDTH  PC of slot 0.
- pkt_inst  in  FETCH_WIDTH*INST_WIDTH  slot i at bits [i*INST_WIDTH +: INST_WIDTH].
- pkt_mask  in  FETCH_WIDTH  bit i set = slot i valid (any pattern legal).
- fifo_data_in  out  ADDR_WIDTH+INST_WIDTH  {pc, inst}, pc in MSBs.
- fifo_push  out  1  push request to fifo.
- fifo_full  in  1  fifo full.
- busy  out  1  held packet has unpushed slots.

Behaviour:
- State:
  - hold_valid (1b)
  - hold_pc
  - hold_inst
  - rem_mask (FETCH_WIDTH), the slots not yet pushed.
- Reset (rst=1 at posedge): hold_valid=0, rem_mask=0. Outputs during and after reset until the next accept: pkt_ready=1, fifo_push=0, busy=0. hold_pc and hold_inst are don't-care.
- busy = hold_valid && (rem_mask != 0). hold_valid=1 with rem_mask=0 never persists.
- Slot selection: cur = index of lowest set bit of rem_mask.
  - fifo_data_in = {hold_pc + cur*INST_BYTES, hold_inst[cur]}, combinational from the hold registers.
  - PC add wraps modulo 2^ADDR_WIDTH.
  - fifo_data_in is don't-care when fifo_push=0.
- fifo_push = busy && !fifo_full && !flush.
- On push: clear bit cur of rem_mask at the next edge.
- last = fifo_push && (rem_mask has exactly one bit set).
- pkt_ready = !flush && (!busy || last). This gives back-to-back packets with no bubble.
- Accept = pkt_valid && pkt_ready. At the edge: hold_pc <= pkt_pc, hold_inst <= pkt_inst, rem_mask <= pkt_mask, hold_valid <= (pkt_mask != 0).
  - An all-zero mask is accepted and silently discarded; nothing is pushed.
  - Accept overrides the clear caused by `last` in the same cycle.
- Latency: packet accepted at edge N → first fifo_push asserted in cycle N+1, combinationally gated by fifo_full. A packet with k valid slots needs ≥k cycles.
- Backpressure:
  - fifo_full=1 → fifo_push=0; state holds; fifo_data_in is stable (same cur) until accepted.
  - pkt_ready=0 while busy and not on the last slot.
- Flush has priority over everything except rst:
  - At the edge: hold_valid=0, rem_mask=0.
  - In the flush cycle itself: fifo_push=0 and pkt_ready=0. No packet is taken the same cycle as flush.
- Simultaneous flush and last push: the push is suppressed (flush gates it), and the packet is dropped.
- Reset mid-packet: identical to flush; remaining slots are lost.
- Ordering: slots are pushed in ascending slot index; packets are pushed in acceptance order.
- pkt_* inputs must be stable while pkt_valid=1 && pkt_ready=0. The splitter does not require this for correctness, because it samples only on accept.

Decomposition:
- Shared package: localparam FETCH_ENTRY_WIDTH = ADDR_WIDTH+INST_WIDTH, plus a packed struct fetch_entry_t {pc, inst}. Both are consumed by the fifo instantiation and by decode.
- One sub-module: lsb_priority_encoder #(WIDTH).
  - Inputs: mask.
  - Outputs: index ($clog2(WIDTH) bits), any, onehot.
  - It yields cur and the clear mask. The "exactly one bit" test is (rem_mask & ~onehot) == 0.

Test Plan:
- Full packet, fifo never full: pkt_pc=0x1000, mask=4'b1111, inst=A,B,C,D → pushes {0x1000,A},{0x1004,B},{0x1008,C},{0x100C,D} in 4 consecutive cycles. pkt_ready=1 on the 4th cycle; a second packet at 0x1010 is pushed starting the very next cycle (no bubble).
- Sparse mask 4'b1010, pkt_pc=0x2000 → exactly 2 pushes: {0x2004,B},{0x200C,D}. Mask 4'b0000 → accepted, zero pushes, pkt_ready stays 1.
- Backpressure: fifo_full=1 for 3 cycles after the first push of a 4-slot packet → fifo_push=0 and fifo_data_in holds slot 1 for those cycles. Afterwards slots 1..3 are pushed in order, with no loss or duplication.
- Flush mid-packet after 2 of 4 pushes → no push in the flush cycle or after it, and pkt_ready=0 in the flush cycle. The next packet's first push is its own slot 0.
- Flush coinciding with the last-slot push and pkt_valid=1 → no push, packet not accepted, busy=0 next cycle.
- Wrap: pkt_pc=0xFFFFFFF8, mask=4'b1111 → pcs 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004. Then rst mid-packet → busy=0, pkt_ready=1, and nothing further is pushed.
